svf_config_table: RTL and testbench

- Parametrised hardware key/value configuration store; the next generation of the svf string-config path.
- Holds DEPTH entries of KEY_W-bit key and VAL_W-bit value, written through a set channel.
- Lookups use a get request channel and a registered response channel with valid/ready handshakes.
- Sits between the testbench-side config writer (DPI-driven or bus-driven) and design/BFM consumers that fetch configuration at runtime.

---
 rtl/svf_config_table.sv | 174 +++++++++++++++++
 tb/tb_svf_config_table.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/svf_config_table.sv
// svf_config_table: DEPTH-entry key/value configuration store.
// Writes arrive on a set channel. Lookups use a get request channel and a
// registered response channel, both with valid/ready handshakes.
// Optional macro SVF_CONFIG_TABLE_CLEAR_EN adds a 'clear' input. A cycle with
// clear high invalidates every entry at the clock edge.
module svf_config_table #(
  parameter int KEY_W = 32,
  parameter int VAL_W = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef SVF_CONFIG_TABLE_CLEAR_EN
  input  logic                         clear,
`endif
  input  logic                         set_valid,
  output logic                         set_ready,
  input  logic [KEY_W-1:0]             set_key,
  input  logic [VAL_W-1:0]             set_val,
  output logic                         set_err,
  input  logic                         get_valid,
  output logic                         get_ready,
  input  logic [KEY_W-1:0]             get_key,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_hit,
  output logic [VAL_W-1:0]             rsp_val,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {IDLE, RSP} state_t;

  state_t             state_q, state_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [KEY_W-1:0]   key_q [DEPTH];
  logic [KEY_W-1:0]   key_d [DEPTH];
  logic [VAL_W-1:0]   val_q [DEPTH];
  logic [VAL_W-1:0]   val_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               set_err_q, set_err_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [VAL_W-1:0]   rsp_val_q, rsp_val_d;

  logic               clear_w;
  logic               set_fire, get_fire;
  logic               set_match, free_found, get_match;
  logic [IDX_W-1:0]   set_idx, free_idx;
  logic [VAL_W-1:0]   get_val;

`ifdef SVF_CONFIG_TABLE_CLEAR_EN
  assign clear_w = clear;
`else
  assign clear_w = 1'b0;
`endif

  assign set_fire = set_valid & set_ready;
  assign get_fire = get_valid & get_ready;

  // Parallel compare of both keys against all valid entries; the descending scan makes the lowest index win
  always_comb begin
    set_match  = 1'b0;
    set_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    get_match  = 1'b0;
    get_val    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (valid_q[i] && (key_q[i] == set_key)) begin
        set_match = 1'b1;
        set_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && (key_q[i] == get_key)) begin
        get_match = 1'b1;
        get_val   = val_q[i];
      end
    end
  end

  // Table update: clear wins, then an accepted set overwrites, allocates, or flags a full-table drop
  always_comb begin
    valid_d   = valid_q;
    key_d     = key_q;
    val_d     = val_q;
    count_d   = count_q;
    set_err_d = 1'b0;
    if (clear_w) begin
      valid_d = '0;
      count_d = '0;
    end else if (set_fire) begin
      if (set_match) begin
        val_d[set_idx] = set_val;
      end else if (free_found) begin
        valid_d[free_idx] = 1'b1;
        key_d[free_idx]   = set_key;
        val_d[free_idx]   = set_val;
        count_d           = count_q + CNT_W'(1);
      end else begin
        set_err_d = 1'b1;
      end
    end
  end

  // Response capture: the lookup result is latched on acceptance and held until the next accepted get
  always_comb begin
    rsp_hit_d = rsp_hit_q;
    rsp_val_d = rsp_val_q;
    if (get_fire) begin
      rsp_hit_d = get_match;
      rsp_val_d = get_val;
    end
  end

  // Control registers with synchronous reset; key/value storage is never reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      count_q   <= '0;
      set_err_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_val_q <= '0;
    end else begin
      valid_q   <= valid_d;
      count_q   <= count_d;
      set_err_q <= set_err_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_val_q <= rsp_val_d;
    end
  end

  // Key/value storage registers
  always_ff @(posedge clk) begin
    key_q <= key_d;
    val_q <= val_d;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: an accepted get enters RSP, and the response handshake returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (get_fire) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: sets always have priority over gets, and clear blocks both channels
  always_comb begin
    set_ready = ~clear_w;
    get_ready = (state_q == IDLE) & ~set_valid & ~clear_w;
    rsp_valid = (state_q == RSP);
  end

  assign set_err = set_err_q;
  assign rsp_hit = rsp_hit_q;
  assign rsp_val = rsp_val_q;
  assign count   = count_q;

endmodule

// File: tb/tb_svf_config_table.sv
// tb_svf_config_table: random and directed stimulus for svf_config_table.
// The reference model is an associative array indexed by key, bounded at DEPTH entries.
// When SVF_CONFIG_TABLE_CLEAR_EN is defined, clear is driven and checked as well.
module tb_svf_config_table;

  localparam int KEY_W = 32;
  localparam int VAL_W = 32;
  localparam int DEPTH = 8;

  logic              clk;
  logic              rst;
  logic              set_valid;
  logic              set_ready;
  logic [KEY_W-1:0]  set_key;
  logic [VAL_W-1:0]  set_val;
  logic              set_err;
  logic              get_valid;
  logic              get_ready;
  logic [KEY_W-1:0]  get_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic [VAL_W-1:0]  rsp_val;
  logic [3:0]        count;
`ifdef SVF_CONFIG_TABLE_CLEAR_EN
  logic              clear;
`endif

  svf_config_table #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SVF_CONFIG_TABLE_CLEAR_EN
    .clear     (clear),
`endif
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_key   (set_key),
    .set_val   (set_val),
    .set_err   (set_err),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .get_key   (get_key),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_val   (rsp_val),
    .count     (count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [VAL_W-1:0] mdl [logic [KEY_W-1:0]];
  bit               m_rsp = 1'b0;
  bit               m_hit = 1'b0;
  logic [VAL_W-1:0] m_val = '0;
  bit               m_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check readies, clock, update the model, check outputs
  task automatic applyStimulus(input bit r, input bit sv, input logic [KEY_W-1:0] sk,
                               input logic [VAL_W-1:0] svl, input bit gv,
                               input logic [KEY_W-1:0] gk, input bit rr, input bit cl);
    bit exp_sr, exp_gr, set_fire, get_fire;
    rst       = r;
    set_valid = sv;
    set_key   = sk;
    set_val   = svl;
    get_valid = gv;
    get_key   = gk;
    rsp_ready = rr;
`ifdef SVF_CONFIG_TABLE_CLEAR_EN
    clear     = cl;
`endif
    #1;
    exp_sr = !cl;
    exp_gr = !m_rsp && !sv && !cl;
    checkOutput("set_ready", 64'(set_ready), 64'(exp_sr));
    checkOutput("get_ready", 64'(get_ready), 64'(exp_gr));
    set_fire = sv && exp_sr;
    get_fire = gv && exp_gr;
    @(posedge clk);
    #1;
    if (r) begin
      mdl.delete();
      m_rsp = 1'b0;
      m_hit = 1'b0;
      m_val = '0;
      m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (cl) mdl.delete();
      if (set_fire) begin
        if (mdl.exists(sk) || mdl.num() < DEPTH) mdl[sk] = svl;
        else m_err = 1'b1;
      end
      if (m_rsp && rr) m_rsp = 1'b0;
      if (get_fire) begin
        m_rsp = 1'b1;
        m_hit = mdl.exists(gk);
        m_val = m_hit ? mdl[gk] : '0;
      end
    end
    checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
    checkOutput("rsp_hit",   64'(rsp_hit),   64'(m_hit));
    checkOutput("rsp_val",   64'(rsp_val),   64'(m_val));
    checkOutput("set_err",   64'(set_err),   64'(m_err));
    checkOutput("count",     64'(count),     64'(mdl.num()));
  endtask

  task automatic doIdle(input bit rr);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, rr, 1'b0);
  endtask

  task automatic doSet(input logic [KEY_W-1:0] k, input logic [VAL_W-1:0] v);
    applyStimulus(1'b0, 1'b1, k, v, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic doGet(input logic [KEY_W-1:0] k);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, k, 1'b0, 1'b0);
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("reset_count", 64'(count), 64'd0);

    doGet(32'h10);
    checkOutput("miss_valid", 64'(rsp_valid), 64'd1);
    checkOutput("miss_hit", 64'(rsp_hit), 64'd0);
    doIdle(1'b1);

    doSet(32'h10, 32'hAAAA);
    doGet(32'h10);
    checkOutput("hit_val", 64'(rsp_val), 64'hAAAA);
    doIdle(1'b1);

    doSet(32'h10, 32'h1234);
    checkOutput("overwrite_count", 64'(count), 64'd1);
    doGet(32'h10);
    doIdle(1'b1);

    for (int i = 1; i < DEPTH; i++) doSet(32'h10 + 32'(i), 32'h100 + 32'(i));
    doSet(32'h99, 32'hDEAD);
    checkOutput("full_err", 64'(set_err), 64'd1);
    doIdle(1'b0);
    checkOutput("full_err_clr", 64'(set_err), 64'd0);
    checkOutput("full_count", 64'(count), 64'd8);
    doGet(32'h99);
    doIdle(1'b1);

    doGet(32'h10);
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h5555, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) doIdle(1'b0);
    checkOutput("held_val", 64'(rsp_val), 64'h1234);
    doIdle(1'b1);
    doGet(32'h10);
    checkOutput("new_val", 64'(rsp_val), 64'h5555);
    doIdle(1'b1);

    applyStimulus(1'b0, 1'b1, 32'h11, 32'h7777, 1'b1, 32'h11, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 32'h11, 1'b0, 1'b0);
    doIdle(1'b1);

`ifdef SVF_CONFIG_TABLE_CLEAR_EN
    applyStimulus(1'b0, 1'b1, 32'h12, 32'h1, 1'b1, 32'h12, 1'b1, 1'b1);
    checkOutput("clear_count", 64'(count), 64'd0);
    doGet(32'h12);
    doIdle(1'b1);
`endif

    for (int n = 0; n < 3000; n++) begin
      bit r, sv, gv, rr, cl;
      r  = ($urandom_range(0, 149) == 0);
      sv = ($urandom_range(0, 2) == 0);
      gv = ($urandom_range(0, 1) == 0);
      rr = ($urandom_range(0, 4) < 3);
`ifdef SVF_CONFIG_TABLE_CLEAR_EN
      cl = ($urandom_range(0, 59) == 0);
`else
      cl = 1'b0;
`endif
      applyStimulus(r, sv, 32'h10 + 32'($urandom_range(0, 11)), $urandom(),
                    gv, 32'h10 + 32'($urandom_range(0, 11)), rr, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
